// File: rtl/knn_point_streamer_if.sv
// Stream interface between the KNN point streamer (master) and the
// distance core (slave): held test point plus a valid/ready point stream.
`timescale 1ns/1ps
interface knn_point_streamer_if #(
  parameter int DATA_W = 40,
  parameter int IDX_W  = 4
);
  logic [DATA_W-1:0] tp;
  logic              pt_valid;
  logic              pt_ready;
  logic [DATA_W-1:0] pt_data;
  logic [IDX_W-1:0]  pt_idx;
  logic              pt_last;

  modport master (
    output tp, pt_valid, pt_data, pt_idx, pt_last,
    input  pt_ready
  );

  modport slave (
    input  tp, pt_valid, pt_data, pt_idx, pt_last,
    output pt_ready
  );
endinterface

// File: rtl/knn_point_streamer.sv
// knn_point_streamer: buffers a test point and up to N labelled dataset points,
// then on start streams the dataset points in write order over a valid/ready
// link to the KNN distance core.
// Point word: [DATA_W-1:32] label, [31:16] X, [15:0] Y.
// Optional build macro KNN_STREAMER_STALL_CNT_EN adds a saturating stall counter
// output (stall_cnt) that counts backpressure cycles of the current stream.
`timescale 1ns/1ps
module knn_point_streamer #(
  parameter  int DATA_W = 40,
  parameter  int N      = 10,
  localparam int IDX_W  = $clog2(N),
  localparam int CNT_W  = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tp_wr,
  input  logic [DATA_W-1:0]  tp_wdata,
  input  logic               pt_wr,
  input  logic [DATA_W-1:0]  pt_wdata,
  input  logic               start,
  knn_point_streamer_if.master pt_if,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               wr_err
`ifdef KNN_STREAMER_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] mem_r [N];
  logic [CNT_W-1:0]  count_r;
  logic [IDX_W-1:0]  rd_idx_r;
  logic [DATA_W-1:0] tp_r;
  logic [DATA_W-1:0] pt_data_r;
  logic              pt_valid_r;
  logic              pt_last_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_err_r;

  logic              wr_acc_s;
  logic              go_s;
  logic              hs_s;
  logic [CNT_W-1:0]  eff_count_s;
  logic [CNT_W-1:0]  last_idx_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  nxt_idx_s;
  logic [DATA_W-1:0] first_data_s;
  logic [DATA_W-1:0] nxt_data_s;

  // Decode write acceptance, stream launch and next-point lookup.
  always_comb begin
    wr_acc_s     = 1'b0;
    go_s         = 1'b0;
    eff_count_s  = count_r;
    first_data_s = mem_r[0];
    if ((state_r == ST_IDLE) && !clr && pt_wr && (count_r != CNT_W'(N))) begin
      wr_acc_s    = 1'b1;
      eff_count_s = count_r + CNT_W'(1);
    end else begin
      wr_acc_s    = 1'b0;
      eff_count_s = count_r;
    end
    if ((state_r == ST_IDLE) && !clr && start && (eff_count_s != CNT_W'(0))) begin
      go_s = 1'b1;
    end else begin
      go_s = 1'b0;
    end
    // An empty buffer with a same-cycle write streams the word being written.
    if (count_r == CNT_W'(0)) begin
      first_data_s = pt_wdata;
    end else begin
      first_data_s = mem_r[0];
    end
    hs_s       = pt_valid_r && pt_if.pt_ready;
    wr_idx_s   = count_r[IDX_W-1:0];
    nxt_idx_s  = rd_idx_r + IDX_W'(1);
    last_idx_s = count_r - CNT_W'(1);
    nxt_data_s = mem_r[nxt_idx_s];
  end

  // Point buffer storage; contents are don't-care after reset or clear.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_idx_s] <= pt_wdata;
    end
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      count_r    <= '0;
      rd_idx_r   <= '0;
      tp_r       <= '0;
      pt_data_r  <= '0;
      pt_valid_r <= 1'b0;
      pt_last_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr_err_r   <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      wr_err_r <= 1'b0;
      if (clr) begin
        // Clear wins over any same-cycle request; the test point survives.
        state_r    <= ST_IDLE;
        count_r    <= '0;
        rd_idx_r   <= '0;
        pt_valid_r <= 1'b0;
        pt_last_r  <= 1'b0;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (tp_wr) begin
              tp_r <= tp_wdata;
            end
            if (pt_wr) begin
              if (wr_acc_s) begin
                count_r <= eff_count_s;
              end else begin
                wr_err_r <= 1'b1;
              end
            end
            if (go_s) begin
              state_r    <= ST_STREAM;
              busy_r     <= 1'b1;
              rd_idx_r   <= '0;
              pt_valid_r <= 1'b1;
              pt_data_r  <= first_data_s;
              pt_last_r  <= (eff_count_s == CNT_W'(1));
            end else if (start) begin
              // Nothing to stream: report completion straight away.
              done_r <= 1'b1;
            end
          end
          ST_STREAM: begin
            if (pt_wr || tp_wr || start) begin
              wr_err_r <= 1'b1;
            end
            if (hs_s) begin
              if (pt_last_r) begin
                state_r    <= ST_IDLE;
                busy_r     <= 1'b0;
                pt_valid_r <= 1'b0;
                pt_last_r  <= 1'b0;
                done_r     <= 1'b1;
              end else begin
                rd_idx_r  <= nxt_idx_s;
                pt_data_r <= nxt_data_s;
                pt_last_r <= (CNT_W'(nxt_idx_s) == last_idx_s);
              end
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            pt_valid_r <= 1'b0;
            pt_last_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef KNN_STREAMER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of backpressured cycles in the current stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (go_s) begin
      stall_cnt_r <= 16'h0000;
    end else if ((state_r == ST_STREAM) && pt_valid_r && !pt_if.pt_ready &&
                 (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

  assign pt_if.tp       = tp_r;
  assign pt_if.pt_valid = pt_valid_r;
  assign pt_if.pt_data  = pt_data_r;
  assign pt_if.pt_idx   = rd_idx_r;
  assign pt_if.pt_last  = pt_last_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign count          = count_r;
  assign wr_err         = wr_err_r;

endmodule

// File: tb/tb_knn_point_streamer.sv
// Directed bench for knn_point_streamer with a scoreboard of expected points.
`timescale 1ns/1ps
module tb_knn_point_streamer;
  localparam int DW = 40;
  localparam int NP = 10;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    i;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          tp_wr = 1'b0;
  logic [DW-1:0] tp_wdata = '0;
  logic          pt_wr = 1'b0;
  logic [DW-1:0] pt_wdata = '0;
  logic          start = 1'b0;
  logic          pt_ready = 1'b0;
  logic          busy, done, wr_err;
  logic [3:0]    count;
`ifdef KNN_STREAMER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  knn_point_streamer_if #(.DATA_W(DW), .IDX_W(4)) pif ();
  assign pif.pt_ready = pt_ready;

  knn_point_streamer #(.DATA_W(DW), .N(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tp_wr    (tp_wr),
    .tp_wdata (tp_wdata),
    .pt_wr    (pt_wr),
    .pt_wdata (pt_wdata),
    .start    (start),
    .pt_if    (pif),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .wr_err   (wr_err)
`ifdef KNN_STREAMER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  logic [DW-1:0] mmem [NP];
  int            mcount = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int lab, input int x, input int y);
    logic [7:0]  l8;
    logic [15:0] x16, y16;
    l8 = 8'(lab); x16 = 16'(x); y16 = 16'(y);
    return {l8, x16, y16};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pt(input logic [DW-1:0] d);
    pt_wr = 1'b1; pt_wdata = d;
    if (mcount < NP) begin
      mmem[mcount] = d;
      mcount++;
    end
    step();
    pt_wr = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
    mcount = 0;
    sb.delete();
  endtask

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < mcount; i++) begin
      e.d = mmem[i]; e.i = 4'(i); e.l = (i == mcount - 1);
      sb.push_back(e);
    end
  endtask

  task automatic do_start();
    push_all();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count valid cycles until done pulses, within a cycle budget.
  task automatic run_to_done(input int bound, input string tag, output int vc);
    logic found;
    found = 1'b0; vc = 0;
    for (int i = 0; i < bound && !found; i++) begin
      if (pif.pt_valid) vc++;
      step();
      if (done) found = 1'b1;
    end
    chk(tag, found, 1'b1);
  endtask

  // Scoreboard monitor: compare each handshake and stall stability.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic [3:0]    stall_idx;
  logic          stall_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst && stall_prev) begin
      chk("hold_valid", pif.pt_valid, 1'b1);
      chk("hold_data", pif.pt_data, stall_data);
      chk("hold_idx", pif.pt_idx, stall_idx);
      chk("hold_last", pif.pt_last, stall_last);
    end
    if (rst && pif.pt_valid && pt_ready && !clr) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", pif.pt_data, e.d);
        chk("sb_idx", pif.pt_idx, e.i);
        chk("sb_last", pif.pt_last, e.l);
      end
    end
    stall_prev = rst && pif.pt_valid && !pt_ready && !clr;
    stall_data = pif.pt_data;
    stall_idx  = pif.pt_idx;
    stall_last = pif.pt_last;
  end

  initial begin
    int vc;
    logic [DW-1:0] tpv;
    tpv = 40'h00_0005_0007;

    // Reset values
    #3;
    chk("rst_valid", pif.pt_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 4'd0);
    chk("rst_tp", pif.tp, 40'd0);
    chk("rst_idx", pif.pt_idx, 4'd0);
    chk("rst_done", done, 1'b0);
    step(); step();
    rst = 1'b1;
    step();

    // Three points, ready held high
    tp_wr = 1'b1; tp_wdata = tpv; step(); tp_wr = 1'b0;
    write_pt(mk(1, 10, 20));
    write_pt(mk(2, 300, 4));
    write_pt(mk(3, 65535, 0));
    chk("t2_count", count, 4'd3);
    pt_ready = 1'b1;
    do_start();
    chk("t2_valid_after_start", pif.pt_valid, 1'b1);
    chk("t2_busy", busy, 1'b1);
    run_to_done(20, "t2_done", vc);
    chk("t2_valid_cycles", vc, 3);
    chk("t2_valid_off", pif.pt_valid, 1'b0);
    chk("t2_tp", pif.tp, tpv);
    step();
    chk("t2_done_pulse", done, 1'b0);

    // Fill to capacity, overflow write, full stream
    do_clr();
    for (int i = 0; i < NP; i++) write_pt(mk(i + 16, i * 7, 1000 - i));
    pt_wr = 1'b1; pt_wdata = mk(99, 1, 1); step(); pt_wr = 1'b0;
    chk("t3_wr_err", wr_err, 1'b1);
    chk("t3_count_full", count, 4'd10);
    step();
    chk("t3_wr_err_pulse", wr_err, 1'b0);
    do_start();
    run_to_done(40, "t3_done", vc);
    chk("t3_valid_cycles", vc, 10);

    // Backpressure pattern 0,0,1 per point over two points
    do_clr();
    write_pt(mk(5, 11, 12));
    write_pt(mk(6, 13, 14));
    pt_ready = 1'b0;
    do_start();
    begin
      logic rp [6];
      rp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        chk("t4_valid", pif.pt_valid, 1'b1);
        pt_ready = rp[i];
        step();
      end
    end
    chk("t4_done", done, 1'b1);
    chk("t4_valid_off", pif.pt_valid, 1'b0);
`ifdef KNN_STREAMER_STALL_CNT_EN
    chk("t4_stall_cnt", stall_cnt, 16'd4);
`endif

    // Clear during idx 1 of 4
    do_clr();
    for (int i = 0; i < 4; i++) write_pt(mk(i + 40, i, i));
    pt_ready = 1'b1;
    do_start();
    step();
    chk("t5_idx1", pif.pt_idx, 4'd1);
    pt_ready = 1'b0;
    clr = 1'b1; step(); clr = 1'b0;
    mcount = 0; sb.delete();
    chk("t5_valid", pif.pt_valid, 1'b0);
    chk("t5_count", count, 4'd0);
    chk("t5_no_done", done, 1'b0);
    chk("t5_busy", busy, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_empty_done", done, 1'b1);
    chk("t5_empty_valid", pif.pt_valid, 1'b0);

    // Same-cycle write and start on an empty buffer
    pt_wr = 1'b1; pt_wdata = mk(7, 77, 88);
    mmem[0] = pt_wdata; mcount = 1;
    push_all();
    start = 1'b1; step(); start = 1'b0; pt_wr = 1'b0;
    chk("t5b_valid", pif.pt_valid, 1'b1);
    chk("t5b_last", pif.pt_last, 1'b1);
    chk("t5b_count", count, 4'd1);
    pt_ready = 1'b1;
    run_to_done(10, "t5b_done", vc);

    // Writes and start while streaming are rejected
    do_clr();
    for (int i = 0; i < 3; i++) write_pt(mk(i + 60, 100 + i, 200 + i));
    pt_ready = 1'b0;
    do_start();
    pt_wr = 1'b1; pt_wdata = mk(9, 9, 9); step(); pt_wr = 1'b0;
    chk("t6_wr_err_pt", wr_err, 1'b1);
    chk("t6_count", count, 4'd3);
    start = 1'b1; step(); start = 1'b0;
    chk("t6_wr_err_start", wr_err, 1'b1);
    chk("t6_busy", busy, 1'b1);
    chk("t6_idx", pif.pt_idx, 4'd0);
    pt_ready = 1'b1;
    run_to_done(20, "t6_done", vc);
    chk("t6_valid_cycles", vc, 3);

    // Replay the same set
    do_start();
    run_to_done(20, "t7_done", vc);
    chk("t7_valid_cycles", vc, 3);

    // Asynchronous reset mid-stream
    pt_ready = 1'b0;
    do_start();
    chk("t1_streaming", pif.pt_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t1_valid", pif.pt_valid, 1'b0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_count", count, 4'd0);
    chk("t1_tp", pif.tp, 40'd0);
    chk("t1_data", pif.pt_data, 40'd0);
    sb.delete(); mcount = 0;
    step();
    rst = 1'b1;
    step();

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
